// File: rtl/fetch_sequencer_if.sv
// Instruction-memory read channel between the fetch sequencer and memory.
//   imem_req  : read request (sequencer -> memory)
//   imem_addr : read address  (sequencer -> memory)
//   imem_ack  : read data valid this cycle (memory -> sequencer)
//   imem_data : instruction word (memory -> sequencer)
interface fetch_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;

  modport master (output imem_req, imem_addr, input imem_ack, imem_data);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_data);
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: BOOT -> FETCH -> DECODE -> EXEC -> UPDATE loop,
// with absorbing HALT (all-ones instruction) and FAULT (fetch timeout) states.
// Ports:
//   CLK, RESET   : clock, synchronous active-low reset
//   startPC      : boot address, word-aligned on load
//   imem         : instruction-memory read channel (master side)
//   instr        : instruction register; instr_valid pulses in DECODE
//   exec_done    : datapath done; branch_taken/branch_off sampled with it
//   pc, retired  : program counter, retired-instruction count
//   halted/fault : high in HALT / FAULT
module fetch_sequencer #(
  parameter int unsigned FETCH_TIMEOUT = 255
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [31:0]         startPC,
  fetch_sequencer_if.master   imem,
  output logic [31:0]         instr,
  output logic                instr_valid,
  input  logic                exec_done,
  input  logic                branch_taken,
  input  logic [31:0]         branch_off,
  output logic [31:0]         pc,
  output logic [31:0]         retired,
  output logic                halted,
  output logic                fault
);

  typedef enum logic [2:0] {
    BOOT, FETCH, DECODE, EXEC, UPDATE, HALT, FAULT
  } state_t;

  localparam logic [15:0] TMO_LAST = 16'(FETCH_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] retired_q, retired_d;
  logic [15:0] tmo_q, tmo_d;
  logic        taken_q, taken_d;
  logic [31:0] off_q, off_d;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q   <= BOOT;
      pc_q      <= '0;
      instr_q   <= '0;
      retired_q <= '0;
      tmo_q     <= '0;
      taken_q   <= 1'b0;
      off_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
      tmo_q     <= tmo_d;
      taken_q   <= taken_d;
      off_q     <= off_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    retired_d = retired_q;
    tmo_d     = tmo_q;
    taken_d   = taken_q;
    off_d     = off_q;
    case (state_q)
      BOOT: begin
        pc_d    = startPC & 32'hFFFF_FFFC;
        tmo_d   = '0;
        state_d = FETCH;
      end
      FETCH: begin
        // An ack on the last permitted cycle takes priority over the timeout.
        if (imem.imem_ack) begin
          instr_d = imem.imem_data;
          tmo_d   = '0;
          state_d = DECODE;
        end else if (tmo_q == TMO_LAST) begin
          tmo_d   = '0;
          state_d = FAULT;
        end else begin
          tmo_d   = tmo_q + 16'd1;
        end
      end
      DECODE: state_d = (instr_q == '1) ? HALT : EXEC;
      EXEC: begin
        if (exec_done) begin
          taken_d = branch_taken;
          off_d   = branch_off;
          state_d = UPDATE;
        end
      end
      UPDATE: begin
        pc_d      = pc_q + 32'd4 + (taken_q ? (off_q << 2) : '0);
        retired_d = retired_q + 32'd1;
        state_d   = FETCH;
      end
      HALT:    state_d = HALT;
      FAULT:   state_d = FAULT;
      default: state_d = BOOT;
    endcase
  end

  assign imem.imem_req  = (state_q == FETCH);
  assign imem.imem_addr = pc_q;
  assign instr          = instr_q;
  assign instr_valid    = (state_q == DECODE);
  assign pc             = pc_q;
  assign retired        = retired_q;
  assign halted         = (state_q == HALT);
  assign fault          = (state_q == FAULT);

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] startPC;
  logic [31:0] instr;
  logic        instr_valid;
  logic        exec_done;
  logic        branch_taken;
  logic [31:0] branch_off;
  logic [31:0] pc;
  logic [31:0] retired;
  logic        halted;
  logic        fault;

  fetch_sequencer_if bus();

  fetch_sequencer #(.FETCH_TIMEOUT(4)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .startPC      (startPC),
    .imem         (bus.master),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .exec_done    (exec_done),
    .branch_taken (branch_taken),
    .branch_off   (branch_off),
    .pc           (pc),
    .retired      (retired),
    .halted       (halted),
    .fault        (fault)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          ack_dly;
    int          exe_dly;
    logic        taken;
    logic [31:0] off;
    logic [31:0] npc;
    logic [31:0] nret;
    logic        noise;
  } vec_t;

  vec_t        tbl[11];
  logic [31:0] sb[$];
  int          checks = 0;
  int          errors = 0;

  function automatic vec_t mk(logic [31:0] addr, logic [31:0] data, int ack_dly,
                              int exe_dly, logic taken, logic [31:0] off,
                              logic [31:0] npc, logic [31:0] nret, logic noise);
    vec_t v;
    v.addr = addr; v.data = data; v.ack_dly = ack_dly; v.exe_dly = exe_dly;
    v.taken = taken; v.off = off; v.npc = npc; v.nret = nret; v.noise = noise;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_req();
    for (int i = 0; i < 16; i++) begin
      if (bus.imem_req) break;
      tick();
    end
    chk("req_seen", {31'd0, bus.imem_req}, 32'd1);
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, "_pc"},      pc, 32'd0);
    chk({tag, "_instr"},   instr, 32'd0);
    chk({tag, "_retired"}, retired, 32'd0);
    chk({tag, "_req"},     {31'd0, bus.imem_req}, 32'd0);
    chk({tag, "_valid"},   {31'd0, instr_valid}, 32'd0);
    chk({tag, "_halted"},  {31'd0, halted}, 32'd0);
    chk({tag, "_fault"},   {31'd0, fault}, 32'd0);
  endtask

  task automatic do_vec(vec_t v);
    int          t0;
    logic [31:0] exp_instr;
    wait_req();
    t0 = cyc;
    chk("fetch_addr", bus.imem_addr, v.addr);
    for (int i = 0; i < v.ack_dly; i++) begin
      bus.imem_ack = 1'b0;
      if (v.noise) begin
        exec_done = 1'b1; branch_taken = 1'b1; branch_off = 32'h0000_1234;
      end
      tick();
      chk("req_held", {31'd0, bus.imem_req}, 32'd1);
    end
    exec_done = 1'b0; branch_taken = 1'b0; branch_off = '0;
    bus.imem_ack  = 1'b1;
    bus.imem_data = v.data;
    sb.push_back(v.data);
    tick();
    bus.imem_ack  = 1'b0;
    bus.imem_data = 32'hDEAD_BEEF;
    chk("decode_valid", {31'd0, instr_valid}, 32'd1);
    exp_instr = (sb.size() > 0) ? sb.pop_front() : 32'hXXXX_XXXX;
    chk("instr", instr, exp_instr);
    if (v.data == 32'hFFFF_FFFF) begin
      tick();
      chk("halt_halted", {31'd0, halted}, 32'd1);
      chk("halt_pc", pc, v.npc);
      chk("halt_retired", retired, v.nret);
      chk("halt_valid", {31'd0, instr_valid}, 32'd0);
      return;
    end
    tick();
    chk("exec_valid_low", {31'd0, instr_valid}, 32'd0);
    for (int i = 0; i < v.exe_dly; i++) begin
      // An all-ones word accepted here would send the sequencer to HALT.
      if (v.noise) begin
        bus.imem_ack = 1'b1; bus.imem_data = 32'hFFFF_FFFF;
      end
      tick();
    end
    bus.imem_ack = 1'b0;
    exec_done = 1'b1; branch_taken = v.taken; branch_off = v.off;
    tick();
    exec_done = 1'b0; branch_taken = 1'b0; branch_off = '0;
    tick();
    chk("next_pc", pc, v.npc);
    chk("retired", retired, v.nret);
    chk("latency", 32'(cyc - t0), 32'(v.ack_dly + v.exe_dly + 4));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    //              addr          data          ack exe tkn off           npc           ret     noise
    tbl[0]  = mk(32'h0000_0100, 32'h0000_0011, 0, 0, 0, 32'h0,         32'h0000_0104, 32'd1,  0);
    tbl[1]  = mk(32'h0000_0104, 32'h0000_0022, 0, 0, 0, 32'h0,         32'h0000_0108, 32'd2,  0);
    tbl[2]  = mk(32'h0000_0108, 32'h0000_0033, 0, 0, 0, 32'h0,         32'h0000_010C, 32'd3,  0);
    tbl[3]  = mk(32'h0000_010C, 32'h0000_0044, 3, 2, 1, 32'h2,         32'h0000_0118, 32'd4,  1);
    tbl[4]  = mk(32'h0000_0118, 32'h0000_0055, 1, 0, 1, 32'h39,        32'h0000_0200, 32'd5,  0);
    tbl[5]  = mk(32'h0000_0200, 32'h0000_0066, 0, 1, 1, 32'hFFFF_FFFD, 32'h0000_01F8, 32'd6,  0);
    tbl[6]  = mk(32'h0000_01F8, 32'h0000_0077, 2, 0, 1, 32'h1,         32'h0000_0200, 32'd7,  0);
    tbl[7]  = mk(32'h0000_0200, 32'h0000_0088, 0, 0, 1, 32'h2,         32'h0000_020C, 32'd8,  0);
    tbl[8]  = mk(32'h0000_020C, 32'h0000_0099, 1, 1, 1, 32'hFFFF_FF7B, 32'hFFFF_FFFC, 32'd9,  1);
    tbl[9]  = mk(32'hFFFF_FFFC, 32'h0000_00AA, 0, 3, 0, 32'h0,         32'h0000_0000, 32'd10, 1);
    tbl[10] = mk(32'h0000_0000, 32'hFFFF_FFFF, 0, 0, 0, 32'h0,         32'h0000_0000, 32'd10, 0);

    RESET = 1'b0; startPC = 32'h0000_0100;
    bus.imem_ack = 1'b0; bus.imem_data = '0;
    exec_done = 1'b0; branch_taken = 1'b0; branch_off = '0;
    tick(); tick();
    chk_reset_vals("rst0");
    RESET = 1'b1;
    tick();

    for (int i = 0; i < 11; i++) do_vec(tbl[i]);

    // HALT absorbs: memory and datapath activity must be ignored.
    for (int i = 0; i < 3; i++) begin
      bus.imem_ack = 1'b1; bus.imem_data = 32'h0000_1111;
      exec_done = 1'b1; branch_taken = 1'b1; branch_off = 32'h10;
      tick();
      chk("halt_stay", {31'd0, halted}, 32'd1);
      chk("halt_req", {31'd0, bus.imem_req}, 32'd0);
      chk("halt_pc_hold", pc, 32'd0);
      chk("halt_ret_hold", retired, 32'd10);
      chk("halt_instr_hold", instr, 32'hFFFF_FFFF);
    end
    bus.imem_ack = 1'b0; exec_done = 1'b0; branch_taken = 1'b0; branch_off = '0;

    // Reset out of HALT, run one instruction into EXEC, then reset mid-EXEC.
    RESET = 1'b0; startPC = 32'h0000_0044;
    tick();
    chk_reset_vals("rst1");
    RESET = 1'b1;
    tick();
    chk("boot_addr", bus.imem_addr, 32'h0000_0044);
    bus.imem_ack = 1'b1; bus.imem_data = 32'h0000_0555;
    tick();
    bus.imem_ack = 1'b0;
    tick();
    tick();
    chk("exec_pc", pc, 32'h0000_0044);
    chk("exec_instr", instr, 32'h0000_0555);
    RESET = 1'b0; startPC = 32'h0000_0003;
    bus.imem_ack = 1'b1; exec_done = 1'b1;
    tick();
    chk_reset_vals("rst2");
    tick();
    chk_reset_vals("rst2_hold");
    bus.imem_ack = 1'b0; exec_done = 1'b0;
    RESET = 1'b1;
    tick();
    chk("boot3_pc", pc, 32'h0000_0000);
    chk("boot3_addr", bus.imem_addr, 32'h0000_0000);
    chk("boot3_req", {31'd0, bus.imem_req}, 32'd1);

    // No ack: fault after the 4th FETCH cycle.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("tmo_wait_req", {31'd0, bus.imem_req}, 32'd1);
      chk("tmo_wait_fault", {31'd0, fault}, 32'd0);
    end
    tick();
    chk("tmo_fault", {31'd0, fault}, 32'd1);
    chk("tmo_req_low", {31'd0, bus.imem_req}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      bus.imem_ack = 1'b1; bus.imem_data = 32'h0000_7777;
      tick();
      chk("fault_stay", {31'd0, fault}, 32'd1);
      chk("fault_req", {31'd0, bus.imem_req}, 32'd0);
      chk("fault_valid", {31'd0, instr_valid}, 32'd0);
      chk("fault_instr", instr, 32'd0);
    end
    bus.imem_ack = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
